// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Brief    : Sequential signed multiply / divide unit for the ALU path.
//            Radix-2 Booth multiply or restoring divide, one bit per cycle,
//            64-bit result on z_high/z_low with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z_high,
    output logic [WIDTH-1:0] z_low,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    // Work register: {P/R[WIDTH:0], Q/D[WIDTH-1:0], q-1}
    localparam int AW = 2 * WIDTH + 2;
    localparam logic [CW-1:0] C_LAST_ITER = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [AW-1:0]    work_q, work_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] z_high_q, z_high_d;
    logic [WIDTH-1:0] z_low_q, z_low_d;
    logic             dz_q, dz_d;

    // Datapath helpers
    logic [WIDTH-1:0] a_in_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   w_p;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   p_sum;
    logic [AW-1:0]    mul_next;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_diff;
    logic [AW-1:0]    div_next;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    // One Booth step and one restoring-division step computed from the work register
    always_comb begin
        a_in_mag = a[WIDTH-1] ? -a : a;
        b_mag    = b_q[WIDTH-1] ? -b_q : b_q;

        // Booth: examine {q0, q-1}, add/subtract sign-extended A, then shift right arithmetically
        w_p   = work_q[AW-1:WIDTH+1];
        a_ext = {a_q[WIDTH-1], a_q};
        case (work_q[1:0])
            2'b01:   p_sum = w_p + a_ext;
            2'b10:   p_sum = w_p - a_ext;
            default: p_sum = w_p;
        endcase
        mul_next = {p_sum[WIDTH], p_sum, work_q[WIDTH:1]};

        // Restoring divide: shift next dividend bit into the remainder, trial subtract
        r_shift = {work_q[2*WIDTH:WIDTH+1], work_q[WIDTH]};
        r_diff  = r_shift - {1'b0, b_mag};
        if (!r_diff[WIDTH]) begin
            div_next = {r_diff, work_q[WIDTH-1:1], 1'b1, 1'b0};
        end else begin
            div_next = {r_shift, work_q[WIDTH-1:1], 1'b0, 1'b0};
        end

        // Both operations leave the high word in the upper half and the low word below it
        res_hi = work_q[2*WIDTH:WIDTH+1];
        res_lo = work_q[WIDTH:1];
    end

    // Next-state and output-register logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        done_d   = 1'b0;
        z_high_d = z_high_q;
        z_low_d  = z_low_q;
        dz_d     = dz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d = op;
                    a_d  = a;
                    b_d  = b;
                    if (op && (b == '0)) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        if (op) begin
                            work_d = {{(WIDTH + 1){1'b0}}, a_in_mag, 1'b0};
                        end else begin
                            work_d = {{(WIDTH + 1){1'b0}}, b, 1'b0};
                        end
                    end
                end
            end
            S_RUN: begin
                work_d = op_q ? div_next : mul_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == C_LAST_ITER) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                if (!op_q) begin
                    z_high_d = res_hi;
                    z_low_d  = res_lo;
                    dz_d     = 1'b0;
                end else if (b_q == '0) begin
                    z_high_d = a_q;
                    z_low_d  = '1;
                    dz_d     = 1'b1;
                end else begin
                    // Truncating division: quotient sign from operand signs, remainder follows dividend
                    z_low_d  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -res_lo : res_lo;
                    z_high_d = a_q[WIDTH-1] ? -res_hi : res_hi;
                    dz_d     = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and result registers with synchronous active-low clear
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            z_high_q <= '0;
            z_low_q  <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            z_high_q <= z_high_d;
            z_low_q  <= z_low_d;
            dz_q     <= dz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign z_high      = z_high_q;
    assign z_low       = z_low_q;
    assign div_by_zero = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Brief    : Self-checking bench for mul_div_unit against a cycle-level
//            behavioural model using native 64-bit arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        op    = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] z_high, z_low;

    int total = 0;
    int bad   = 0;
    logic armed = 1'b0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .z_high      (z_high),
        .z_low       (z_low),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    // Arithmetic reference: what the 64-bit result must be
    function automatic void model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint sx, sy, p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o) begin
            p  = sx * sy;
            hi = p[63:32];
            lo = p[31:0];
            dz = 1'b0;
        end else if (y == 32'd0) begin
            hi = x;
            lo = 32'hFFFFFFFF;
            dz = 1'b1;
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            hi = r[31:0];
            lo = q[31:0];
            dz = 1'b0;
        end
    endfunction

    // Cycle-level expectation: busy countdown, done in last busy cycle
    int          rem = 0;
    logic        exp_busy = 0, exp_done = 0, exp_dz = 0;
    logic [31:0] exp_zh = '0, exp_zl = '0;
    logic [31:0] p_hi, p_lo;
    logic        p_dz;

    always @(posedge clock) begin
        if (!clear) begin
            rem = 0; exp_busy = 0; exp_done = 0; exp_zh = '0; exp_zl = '0; exp_dz = 0;
        end else if (rem == 0) begin
            exp_done = 0;
            exp_busy = 0;
            if (start) begin
                model(op, a, b, p_hi, p_lo, p_dz);
                rem      = (op && b == 32'd0) ? 2 : 34;
                exp_busy = 1;
            end
        end else begin
            rem--;
            if (rem == 1) begin
                exp_done = 1; exp_zh = p_hi; exp_zl = p_lo; exp_dz = p_dz;
            end else if (rem == 0) begin
                exp_done = 0; exp_busy = 0;
            end
        end
    end

    // Every-cycle compare of all outputs against the model
    always @(negedge clock) begin
        if (armed) begin
            total++;
            if ({busy, done, z_high, z_low, div_by_zero} !== {exp_busy, exp_done, exp_zh, exp_zl, exp_dz}) begin
                bad++;
                $display("FAIL cycle_check t=%0t got busy=%b done=%b zh=%h zl=%h dz=%b need busy=%b done=%b zh=%h zl=%h dz=%b",
                         $time, busy, done, z_high, z_low, div_by_zero,
                         exp_busy, exp_done, exp_zh, exp_zl, exp_dz);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h need=%h", name, act, exp);
        end
    endtask

    // Launch one op and check latency and result against literal/model values
    task automatic do_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed, input int lat);
        int k;
        @(negedge clock);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        k = 1;
        while (!done && k < 100) begin
            @(negedge clock);
            k++;
        end
        check("latency", 64'(k), 64'(lat));
        check("z_high", 64'(z_high), 64'(eh));
        check("z_low", 64'(z_low), 64'(el));
        check("div_by_zero", 64'(div_by_zero), 64'(ed));
    endtask

    logic [31:0] mh, ml;
    logic        md;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Pin the model with hand-computed values
        model(1'b0, 32'd7, 32'hFFFFFFFD, mh, ml, md);
        check("pin_mul_sign", {mh, ml}, {32'hFFFFFFFF, 32'hFFFFFFEB});
        model(1'b0, 32'h80000000, 32'h80000000, mh, ml, md);
        check("pin_mul_min", {mh, ml}, {32'h40000000, 32'h00000000});
        model(1'b1, 32'hFFFFFFF9, 32'd2, mh, ml, md);
        check("pin_div_neg", {mh, ml}, {32'hFFFFFFFF, 32'hFFFFFFFD});
        model(1'b1, 32'h80000000, 32'hFFFFFFFF, mh, ml, md);
        check("pin_div_ovf", {mh, ml}, {32'h00000000, 32'h80000000});

        // Reset
        clear = 1'b0;
        @(negedge clock);
        @(negedge clock);
        armed = 1'b1;
        check("reset_outputs", {31'd0, busy, done, div_by_zero, z_high}, 64'd0);
        check("reset_zlow", 64'(z_low), 64'd0);
        clear = 1'b1;

        // Directed cases from the plan
        do_op(1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34);
        do_op(1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 34);
        do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 34);
        do_op(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
        do_op(1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 34);
        do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34);
        do_op(1'b1, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1'b1, 2);
        do_op(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);

        // Start while busy is ignored
        begin
            int dones, dcyc;
            dones = 0; dcyc = 0;
            @(negedge clock);
            op = 1'b0; a = 32'd3; b = 32'd4; start = 1'b1;
            for (int k = 1; k <= 45; k++) begin
                @(negedge clock);
                start = (k == 10);
                if (k == 10) begin a = 32'd5; b = 32'd6; end
                if (done) begin dones++; dcyc = k; end
                if (k == 34) check("busy_start_zlow", 64'(z_low), 64'd12);
            end
            check("busy_start_dones", 64'(dones), 64'd1);
            check("busy_start_cycle", 64'(dcyc), 64'd34);
        end

        // Mid-operation reset
        begin
            int dones;
            dones = 0;
            @(negedge clock);
            op = 1'b0; a = 32'd9; b = 32'd9; start = 1'b1;
            for (int k = 1; k <= 15; k++) begin
                @(negedge clock);
                start = 1'b0;
            end
            clear = 1'b0;
            @(negedge clock);
            clear = 1'b1;
            check("midreset_state", {busy, done, z_high, z_low}, 66'd0);
            for (int k = 0; k < 30; k++) begin
                @(negedge clock);
                if (done) dones++;
            end
            check("midreset_no_done", 64'(dones), 64'd0);
        end
        do_op(1'b0, 32'd11, 32'd13, 32'd0, 32'd143, 1'b0, 34);

        // Back-to-back with start held high
        begin
            int d1, d2, n;
            d1 = 0; d2 = 0; n = 0;
            @(negedge clock);
            op = 1'b0; a = 32'd2; b = 32'd3; start = 1'b1;
            for (int k = 1; k <= 69; k++) begin
                @(negedge clock);
                if (done) begin
                    n++;
                    if (n == 1) d1 = k; else d2 = k;
                end
            end
            start = 1'b0;
            check("b2b_first", 64'(d1), 64'd34);
            check("b2b_second", 64'(d2), 64'd69);
            @(negedge clock);
        end

        // Randomised operations
        for (int i = 0; i < 40; i++) begin
            logic        ro;
            logic [31:0] ra, rb;
            ro = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h80000000;
                2: rb = 32'hFFFFFFFF;
                3: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            model(ro, ra, rb, mh, ml, md);
            do_op(ro, ra, rb, mh, ml, md, (ro && rb == 32'd0) ? 2 : 34);
        end

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
